// File: rtl/ps2_key_tracker_if.sv
// Key event stream between the PS/2 tracker and its consumer.
// The tracker drives the FIFO head; the consumer pops with evt_rd.
interface ps2_key_tracker_if #(
  parameter int W = 4
) ();
  logic         evt_valid;
  logic [W-1:0] evt_data;
  logic         evt_rd;

  modport master (
    output evt_valid,
    output evt_data,
    input  evt_rd
  );

  modport slave (
    input  evt_valid,
    input  evt_data,
    output evt_rd
  );
endinterface

// File: rtl/ps2_key_tracker.sv
// PS/2 keyboard receiver with E0/F0 prefix decode, a pressed-key
// bitmap for programmable scan codes and a press/release event FIFO.
module ps2_key_tracker #(
  parameter int NUM_KEYS    = 6,
  parameter int FILTER_LEN  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ps2c,
  input  logic                  ps2d,
  input  logic [9*NUM_KEYS-1:0] key_codes,
  output logic [NUM_KEYS-1:0]   key_down,
  ps2_key_tracker_if.master     evt,
  output logic [7:0]            rx_byte,
  output logic                  rx_byte_vld,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int IDX_W = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
  localparam int EW    = IDX_W + 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int FW    = $clog2(FILTER_LEN);
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PAR,
    S_STOP
  } rx_state_t;

  logic          r_c_s1, r_c_s2;
  logic          r_d_s1, r_d_s2;
  logic [FW-1:0] r_fcnt;
  logic          r_cf, r_cf_d;
  logic          w_fall;

  rx_state_t     r_state, w_state_n;
  logic [7:0]    r_shift, w_shift_n;
  logic [2:0]    r_bcnt, w_bcnt_n;
  logic          r_par, w_par_n;
  logic [TW-1:0] r_tcnt, w_tcnt_n;
  logic          w_good, w_err;

  logic [7:0]    r_rx_byte;
  logic          r_rx_vld;
  logic          r_ferr;

  logic                r_ext, r_brk;
  logic [NUM_KEYS-1:0] r_key_down;
  logic [8:0]          w_code;
  logic                w_is_pfx;
  logic                w_dec;
  logic [NUM_KEYS-1:0] w_match;
  logic [NUM_KEYS-1:0] w_chg;
  logic                w_push;
  logic [IDX_W-1:0]    w_idx;

  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_ovf;
  logic          w_full, w_pop, w_wr;

  // Two-flop synchronisers; PS/2 lines idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_c_s1 <= 1'b1;
      r_c_s2 <= 1'b1;
      r_d_s1 <= 1'b1;
      r_d_s2 <= 1'b1;
    end else begin
      r_c_s1 <= ps2c;
      r_c_s2 <= r_c_s1;
      r_d_s1 <= ps2d;
      r_d_s2 <= r_d_s1;
    end
  end

  // Clock glitch filter: follow ps2c only after FILTER_LEN stable samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fcnt <= '0;
      r_cf   <= 1'b1;
      r_cf_d <= 1'b1;
    end else begin
      r_cf_d <= r_cf;
      if (r_c_s2 == r_cf) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FW'(FILTER_LEN - 1)) begin
        r_cf   <= r_c_s2;
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + 1'b1;
      end
    end
  end

  assign w_fall = r_cf_d & ~r_cf;

  // Frame receiver next-state, bit capture and timeout.
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bcnt_n  = r_bcnt;
    w_par_n   = r_par;
    w_good    = 1'b0;
    w_err     = 1'b0;
    if (r_state == S_IDLE || w_fall)
      w_tcnt_n = '0;
    else
      w_tcnt_n = r_tcnt + 1'b1;
    unique case (r_state)
      S_IDLE: begin
        if (w_fall && !r_d_s2) begin
          w_state_n = S_DATA;
          w_bcnt_n  = '0;
        end
      end
      S_DATA: begin
        if (w_fall) begin
          w_shift_n = {r_d_s2, r_shift[7:1]};
          w_bcnt_n  = r_bcnt + 1'b1;
          if (r_bcnt == 3'd7)
            w_state_n = S_PAR;
        end
      end
      S_PAR: begin
        if (w_fall) begin
          w_par_n   = r_d_s2;
          w_state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (w_fall) begin
          w_state_n = S_IDLE;
          if (r_d_s2 && (^r_shift ^ r_par))
            w_good = 1'b1;
          else
            w_err = 1'b1;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    if (r_state != S_IDLE && !w_fall &&
        r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
      w_state_n = S_IDLE;
      w_err     = 1'b1;
      w_tcnt_n  = '0;
    end
  end

  // Receiver state and the registered byte/error pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bcnt    <= '0;
      r_par     <= 1'b0;
      r_tcnt    <= '0;
      r_rx_byte <= '0;
      r_rx_vld  <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_shift  <= w_shift_n;
      r_bcnt   <= w_bcnt_n;
      r_par    <= w_par_n;
      r_tcnt   <= w_tcnt_n;
      r_rx_vld <= w_good;
      r_ferr   <= w_err;
      if (w_good)
        r_rx_byte <= r_shift;
    end
  end

  // Match the received code against the key table; pick the pushed key.
  always_comb begin
    w_code   = {r_ext, r_rx_byte};
    w_is_pfx = (r_rx_byte == 8'hE0) || (r_rx_byte == 8'hF0);
    w_dec    = r_rx_vld && !w_is_pfx;
    w_match  = '0;
    w_chg    = '0;
    w_push   = 1'b0;
    w_idx    = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_match[i] = (key_codes[9*i +: 9] == w_code);
      w_chg[i]   = w_dec && w_match[i] && (r_key_down[i] == r_brk);
    end
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (w_chg[i]) begin
        w_push = 1'b1;
        w_idx  = IDX_W'(i);
      end
    end
  end

  // Prefix flags and the live pressed bitmap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ext      <= 1'b0;
      r_brk      <= 1'b0;
      r_key_down <= '0;
    end else if (r_ferr) begin
      r_ext <= 1'b0;
      r_brk <= 1'b0;
    end else if (r_rx_vld) begin
      if (r_rx_byte == 8'hE0) begin
        r_ext <= 1'b1;
      end else if (r_rx_byte == 8'hF0) begin
        r_brk <= 1'b1;
      end else begin
        r_ext <= 1'b0;
        r_brk <= 1'b0;
        for (int i = 0; i < NUM_KEYS; i++)
          if (w_match[i])
            r_key_down[i] <= ~r_brk;
      end
    end
  end

  assign w_full = (r_cnt == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = evt.evt_rd && (r_cnt != '0);
  assign w_wr   = w_push && (!w_full || w_pop);

  // Event FIFO; a push on a full FIFO is accepted only alongside a pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++)
        r_mem[i] <= '0;
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wp] <= {r_brk, w_idx};
        r_wp        <= r_wp + 1'b1;
      end
      if (w_pop)
        r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      if (w_push && w_full && !w_pop)
        r_ovf <= 1'b1;
    end
  end

  assign key_down      = r_key_down;
  assign evt.evt_valid = (r_cnt != '0);
  assign evt.evt_data  = r_mem[r_rp];
  assign rx_byte       = r_rx_byte;
  assign rx_byte_vld   = r_rx_vld;
  assign frame_err     = r_ferr;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: frames, prefixes, errors,
// timeout, FIFO overflow/order, clock glitches and mid-frame reset.
module tb_ps2_key_tracker;
  localparam int NK   = 6;
  localparam int IW   = 3;
  localparam int TO   = 2000;
  localparam int HALF = 30;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ps2c = 1'b1;
  logic            ps2d = 1'b1;
  logic [9*NK-1:0] key_codes;
  logic [NK-1:0]   key_down;
  logic [7:0]      rx_byte;
  logic            rx_byte_vld;
  logic            frame_err;
  logic            overflow;

  ps2_key_tracker_if #(.W(IW+1)) evt ();

  ps2_key_tracker #(
    .NUM_KEYS(NK),
    .FILTER_LEN(8),
    .FIFO_DEPTH(4),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2c(ps2c),
    .ps2d(ps2d),
    .key_codes(key_codes),
    .key_down(key_down),
    .evt(evt),
    .rx_byte(rx_byte),
    .rx_byte_vld(rx_byte_vld),
    .frame_err(frame_err),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_bad  = 0;
  int n_vld  = 0;
  int n_ferr = 0;

  always @(negedge clk) begin
    if (rx_byte_vld) n_vld++;
    if (frame_err)   n_ferr++;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b, input bit g = 1'b0);
    ps2d = b;
    if (g) begin
      wclk(14);
      ps2c = 1'b0;
      wclk(3);
      ps2c = 1'b1;
      wclk(HALF - 17);
    end else begin
      wclk(HALF);
    end
    ps2c = 1'b0;
    wclk(HALF);
    ps2c = 1'b1;
  endtask

  task automatic send(input logic [7:0] b,
                      input bit bad = 1'b0,
                      input bit g = 1'b0);
    logic p;
    p = ~(^b);
    if (bad) p = ~p;
    ps2_bit(1'b0, g);
    for (int i = 0; i < 8; i++)
      ps2_bit(b[i], g);
    ps2_bit(p, g);
    ps2_bit(1'b1, g);
    ps2d = 1'b1;
    wclk(40);
  endtask

  task automatic pop();
    evt.evt_rd = 1'b1;
    wclk(1);
    evt.evt_rd = 1'b0;
    wclk(2);
  endtask

  initial begin
    evt.evt_rd = 1'b0;
    key_codes = {9'h175, 9'h029, 9'h023, 9'h01B, 9'h01C, 9'h01D};
    wclk(5);
    rst = 1'b0;
    wclk(20);

    chk("rst key_down", 32'(key_down), 32'h0);
    chk("rst evt_valid", 32'(evt.evt_valid), 32'h0);
    chk("rst evt_data", 32'(evt.evt_data), 32'h0);
    chk("rst overflow", 32'(overflow), 32'h0);
    chk("rst rx_byte", 32'(rx_byte), 32'h0);

    // T1 press, typematic repeat, release
    send(8'h1D);
    chk("t1 rx_byte", 32'(rx_byte), 32'h1D);
    chk("t1 n_vld", 32'(n_vld), 32'd1);
    chk("t1 key_down", 32'(key_down), 32'h01);
    chk("t1 evt_valid", 32'(evt.evt_valid), 32'h1);
    chk("t1 evt_data", 32'(evt.evt_data), 32'h0);
    send(8'h1D);
    chk("t1 rep key_down", 32'(key_down), 32'h01);
    pop();
    chk("t1 rep no evt", 32'(evt.evt_valid), 32'h0);
    send(8'hF0);
    send(8'h1D);
    chk("t1 rel key_down", 32'(key_down), 32'h00);
    chk("t1 rel evt_valid", 32'(evt.evt_valid), 32'h1);
    chk("t1 rel evt_data", 32'(evt.evt_data), 32'h8);
    pop();
    chk("t1 empty", 32'(evt.evt_valid), 32'h0);

    // T2 extended key
    send(8'hE0);
    send(8'h75);
    chk("t2 key_down", 32'(key_down), 32'h20);
    chk("t2 evt_data", 32'(evt.evt_data), 32'h5);
    pop();
    send(8'h75);
    chk("t2 plain75 key_down", 32'(key_down), 32'h20);
    chk("t2 plain75 no evt", 32'(evt.evt_valid), 32'h0);
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    chk("t2 rel key_down", 32'(key_down), 32'h00);
    chk("t2 rel evt_data", 32'(evt.evt_data), 32'hD);
    pop();

    // T3 parity error clears pending prefix
    send(8'hF0);
    send(8'h1D, 1'b1);
    chk("t3 n_ferr", 32'(n_ferr), 32'd1);
    chk("t3 rx_byte kept", 32'(rx_byte), 32'hF0);
    chk("t3 key_down", 32'(key_down), 32'h00);
    chk("t3 no evt", 32'(evt.evt_valid), 32'h0);
    send(8'h1C);
    chk("t3 next key_down", 32'(key_down), 32'h02);
    chk("t3 next evt_data", 32'(evt.evt_data), 32'h1);
    pop();
    send(8'hF0);
    send(8'h1C);
    chk("t3 rel key_down", 32'(key_down), 32'h00);
    pop();
    chk("t3 empty", 32'(evt.evt_valid), 32'h0);

    // T4 timeout on a truncated frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2d = 1'b1;
    wclk(TO + 100);
    chk("t4 n_ferr", 32'(n_ferr), 32'd2);
    send(8'h29);
    chk("t4 key_down", 32'(key_down), 32'h10);
    chk("t4 evt_data", 32'(evt.evt_data), 32'h4);
    send(8'hF0);
    send(8'h29);
    pop();
    pop();
    chk("t4 empty", 32'(evt.evt_valid), 32'h0);

    // T5 overflow and FIFO order
    send(8'h1D);
    send(8'h1C);
    send(8'h1B);
    send(8'h23);
    send(8'h29);
    chk("t5 key_down", 32'(key_down), 32'h1F);
    chk("t5 overflow", 32'(overflow), 32'h1);
    chk("t5 evt_valid", 32'(evt.evt_valid), 32'h1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t5 pop%0d", k), 32'(evt.evt_data), 32'(k));
      pop();
    end
    chk("t5 empty", 32'(evt.evt_valid), 32'h0);

    // T6 glitches while idle with data low, then inside a frame
    ps2d = 1'b0;
    repeat (5) begin
      wclk(10);
      ps2c = 1'b0;
      wclk(3);
      ps2c = 1'b1;
    end
    wclk(20);
    ps2d = 1'b1;
    wclk(20);
    send(8'hF0);
    send(8'h1B, 1'b0, 1'b1);
    chk("t6 n_ferr", 32'(n_ferr), 32'd2);
    chk("t6 rx_byte", 32'(rx_byte), 32'h1B);
    chk("t6 key_down", 32'(key_down), 32'h1B);
    chk("t6 evt_data", 32'(evt.evt_data), 32'hA);
    chk("t6 overflow held", 32'(overflow), 32'h1);

    // T6 reset mid-frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    rst = 1'b1;
    wclk(5);
    chk("t6 rst key_down", 32'(key_down), 32'h0);
    chk("t6 rst evt_valid", 32'(evt.evt_valid), 32'h0);
    chk("t6 rst overflow", 32'(overflow), 32'h0);
    chk("t6 rst rx_byte", 32'(rx_byte), 32'h0);
    chk("t6 rst rx_vld", 32'(rx_byte_vld), 32'h0);
    ps2c = 1'b1;
    ps2d = 1'b1;
    wclk(5);
    rst = 1'b0;
    wclk(TO + 100);
    chk("t6 rst no ferr", 32'(n_ferr), 32'd2);
    chk("t6 rst frame_err", 32'(frame_err), 32'h0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
